// File: rtl/seg_display_decoder.sv
// Seven-segment readback checker: samples the four timer digits after each 1 Hz tick,
// decodes them to BCD and flags bad patterns / bad count steps. Optional macro: SEG_STEP_CHECK_EN.
module seg_display_decoder #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk_50M,
    input  logic       set_n,
    input  logic       tick_1Hz,
    input  logic [6:0] hex_m1,
    input  logic [6:0] hex_m2,
    input  logic [6:0] hex_s1,
    input  logic [6:0] hex_s2,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       frame_valid,
    output logic       frame_strobe,
    output logic       decode_err,
    output logic       step_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, CHECK} state_t;

    function automatic logic [3:0] seg2bcd(input logic [6:0] p);
        case (p)
            7'h40:   return 4'd0;
            7'h79:   return 4'd1;
            7'h24:   return 4'd2;
            7'h30:   return 4'd3;
            7'h19:   return 4'd4;
            7'h12:   return 4'd5;
            7'h02:   return 4'd6;
            7'h78:   return 4'd7;
            7'h00:   return 4'd8;
            7'h10:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q, sync1_d, sync2_d, sync3_d;
    logic [7:0]       cnt_q, cnt_d;
    // digit index: 3=m1, 2=m2, 1=s1, 0=s2
    logic [3:0][6:0]  raw_q, raw_d;
    logic [3:0][3:0]  dig_q, dig_d, dec, dig_fix;
    logic             legal_q, legal_d;
    logic [7:0]       min_bcd_q, min_bcd_d, sec_bcd_q, sec_bcd_d, err_count_q, err_count_d;
    logic             frame_valid_q, frame_valid_d, frame_strobe_q, frame_strobe_d;
    logic             decode_err_q, decode_err_d, step_err_q, step_err_d;
    logic             rise, step_bad;

`ifdef SEG_STEP_CHECK_EN
    logic [12:0]      prev_q, prev_d, cur_tot;
    logic             have_prev_q, have_prev_d;

    assign cur_tot = 13'(dig_q[3]) * 13'd600 + 13'(dig_q[2]) * 13'd60
                   + 13'(dig_q[1]) * 13'd10 + 13'(dig_q[0]);
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dec
        assign dec[g] = seg2bcd(raw_q[g]);
    end

    // seconds tens can never legally exceed 5
    always_comb begin
        dig_fix = dec;
        if (dec[1] > 4'd5) dig_fix[1] = 4'hF;
    end

    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        sync1_d        = tick_1Hz;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        raw_d          = raw_q;
        dig_d          = dig_q;
        legal_d        = legal_q;
        min_bcd_d      = min_bcd_q;
        sec_bcd_d      = sec_bcd_q;
        frame_valid_d  = frame_valid_q;
        frame_strobe_d = 1'b0;
        decode_err_d   = decode_err_q;
        step_err_d     = step_err_q;
        err_count_d    = err_count_q;
        step_bad       = 1'b0;
`ifdef SEG_STEP_CHECK_EN
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                    raw_d   = {hex_m1, hex_m2, hex_s1, hex_s2};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                dig_d   = dig_fix;
                legal_d = (dig_fix[3] != 4'hF) && (dig_fix[2] != 4'hF)
                       && (dig_fix[1] != 4'hF) && (dig_fix[0] != 4'hF);
                state_d = CHECK;
            end
            CHECK: begin
                state_d        = IDLE;
                frame_strobe_d = 1'b1;
                min_bcd_d      = {dig_q[3], dig_q[2]};
                sec_bcd_d      = {dig_q[1], dig_q[0]};
                frame_valid_d  = legal_q;
                if (!legal_q) decode_err_d = 1'b1;
`ifdef SEG_STEP_CHECK_EN
                if (legal_q) begin
                    // a zero previous total only permits holding at 00:00
                    if (have_prev_q && !((cur_tot == prev_q) ||
                        ((prev_q != 13'd0) && (cur_tot == prev_q - 13'd1))))
                        step_bad = 1'b1;
                    prev_d      = cur_tot;
                    have_prev_d = 1'b1;
                end else begin
                    have_prev_d = 1'b0;
                end
`endif
                if (step_bad) step_err_d = 1'b1;
                if ((!legal_q || step_bad) && (err_count_q != 8'hFF))
                    err_count_d = err_count_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!set_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            cnt_q          <= 8'd0;
            raw_q          <= '0;
            dig_q          <= '0;
            legal_q        <= 1'b0;
            min_bcd_q      <= 8'd0;
            sec_bcd_q      <= 8'd0;
            frame_valid_q  <= 1'b0;
            frame_strobe_q <= 1'b0;
            decode_err_q   <= 1'b0;
            step_err_q     <= 1'b0;
            err_count_q    <= 8'd0;
`ifdef SEG_STEP_CHECK_EN
            prev_q         <= 13'd0;
            have_prev_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            cnt_q          <= cnt_d;
            raw_q          <= raw_d;
            dig_q          <= dig_d;
            legal_q        <= legal_d;
            min_bcd_q      <= min_bcd_d;
            sec_bcd_q      <= sec_bcd_d;
            frame_valid_q  <= frame_valid_d;
            frame_strobe_q <= frame_strobe_d;
            decode_err_q   <= decode_err_d;
            step_err_q     <= step_err_d;
            err_count_q    <= err_count_d;
`ifdef SEG_STEP_CHECK_EN
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
`endif
        end
    end

    assign min_bcd      = min_bcd_q;
    assign sec_bcd      = sec_bcd_q;
    assign frame_valid  = frame_valid_q;
    assign frame_strobe = frame_strobe_q;
    assign decode_err   = decode_err_q;
    assign step_err     = step_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder: table of frames plus hand sequences for
// double ticks, counter saturation and mid-frame reset.
module tb_seg_display_decoder;

    localparam int SETTLE = 8;
`ifdef SEG_STEP_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic       clk_50M = 1'b0;
    logic       set_n = 1'b0;
    logic       tick_1Hz = 1'b0;
    logic [6:0] hex_m1 = 7'h7F, hex_m2 = 7'h7F, hex_s1 = 7'h7F, hex_s2 = 7'h7F;
    logic [7:0] min_bcd, sec_bcd, err_count;
    logic       frame_valid, frame_strobe, decode_err, step_err;

    int checks = 0;
    int failures = 0;

    seg_display_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_50M(clk_50M), .set_n(set_n), .tick_1Hz(tick_1Hz),
        .hex_m1(hex_m1), .hex_m2(hex_m2), .hex_s1(hex_s1), .hex_s2(hex_s2),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .frame_valid(frame_valid),
        .frame_strobe(frame_strobe), .decode_err(decode_err), .step_err(step_err),
        .err_count(err_count)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic       rst;
        logic [6:0] m1, m2, s1, s2;
        logic [7:0] emin, esec;
        logic       ev, ed, es_on;
        logic [7:0] ec_on, ec_off;
    } vec_t;

    vec_t v[17];
    int   lat;
    logic strobe_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50M);
        set_n = 1'b0;
        tick_1Hz = 1'b0;
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M);
        set_n = 1'b1;
    endtask

    // Raises tick with the given patterns; lat = edges from first high sample to strobe (-1 on timeout).
    task automatic do_frame(input logic [6:0] a, b, c, d, output int l, output logic after);
        @(negedge clk_50M);
        hex_m1 = a; hex_m2 = b; hex_s1 = c; hex_s2 = d;
        tick_1Hz = 1'b1;
        l = -1;
        after = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_50M);
            #1;
            if (frame_strobe) begin
                l = k;
                break;
            end
        end
        @(posedge clk_50M);
        #1 after = frame_strobe;
        @(negedge clk_50M);
        tick_1Hz = 1'b0;
        repeat (4) @(posedge clk_50M);
    endtask

    initial begin
        v[0]  = '{1'b1, 7'h40, 7'h12, 7'h40, 7'h40, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[1]  = '{1'b1, 7'h79, 7'h40, 7'h40, 7'h40, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[2]  = '{1'b0, 7'h40, 7'h10, 7'h12, 7'h10, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[3]  = '{1'b0, 7'h40, 7'h10, 7'h12, 7'h10, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[4]  = '{1'b0, 7'h40, 7'h10, 7'h12, 7'h00, 8'h09, 8'h58, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[5]  = '{1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[6]  = '{1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[7]  = '{1'b0, 7'h40, 7'h40, 7'h40, 7'h12, 8'h00, 8'h05, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0};
        v[8]  = '{1'b1, 7'h40, 7'h79, 7'h40, 7'h40, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[9]  = '{1'b0, 7'h40, 7'h40, 7'h12, 7'h10, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        v[10] = '{1'b1, 7'h40, 7'h40, 7'h02, 7'h40, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
        v[11] = '{1'b0, 7'h40, 7'h7F, 7'h40, 7'h40, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2};
        v[12] = '{1'b0, 7'h40, 7'h30, 7'h40, 7'h40, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2};
        v[13] = '{1'b0, 7'h40, 7'h24, 7'h12, 7'h10, 8'h02, 8'h59, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2};
        v[14] = '{1'b0, 7'h40, 7'h24, 7'h12, 7'h7E, 8'h02, 8'h5F, 1'b0, 1'b1, 1'b0, 8'd3, 8'd3};
        v[15] = '{1'b0, 7'h40, 7'h24, 7'h12, 7'h12, 8'h02, 8'h55, 1'b1, 1'b1, 1'b0, 8'd3, 8'd3};
        v[16] = '{1'b0, 7'h40, 7'h24, 7'h12, 7'h40, 8'h02, 8'h50, 1'b1, 1'b1, 1'b1, 8'd4, 8'd3};

        do_reset();
        #1;
        chk("reset_min", 32'(min_bcd), 32'h0);
        chk("reset_sec", 32'(sec_bcd), 32'h0);
        chk("reset_flags", {28'd0, frame_valid, frame_strobe, decode_err, step_err}, 32'h0);
        chk("reset_errcnt", 32'(err_count), 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (v[i].rst) do_reset();
            do_frame(v[i].m1, v[i].m2, v[i].s1, v[i].s2, lat, strobe_after);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(SETTLE + 4));
            chk($sformatf("v%0d_strobe_1cyc", i), 32'(strobe_after), 32'h0);
            chk($sformatf("v%0d_min", i), 32'(min_bcd), 32'(v[i].emin));
            chk($sformatf("v%0d_sec", i), 32'(sec_bcd), 32'(v[i].esec));
            chk($sformatf("v%0d_valid", i), 32'(frame_valid), 32'(v[i].ev));
            chk($sformatf("v%0d_decode_err", i), 32'(decode_err), 32'(v[i].ed));
            chk($sformatf("v%0d_step_err", i), 32'(step_err), 32'(SC ? v[i].es_on : 1'b0));
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(SC ? v[i].ec_on : v[i].ec_off));
        end

        // second rise 3 cycles after the first is dropped
        begin
            int strobes = 0;
            int first = -1;
            do_reset();
            @(negedge clk_50M);
            hex_m1 = 7'h40; hex_m2 = 7'h79; hex_s1 = 7'h40; hex_s2 = 7'h40;
            tick_1Hz = 1'b1;
            for (int k = 0; k < 60; k++) begin
                @(posedge clk_50M);
                #1;
                if (frame_strobe) begin
                    strobes++;
                    if (first < 0) first = k;
                end
                @(negedge clk_50M);
                if (k == 0) tick_1Hz = 1'b0;
                if (k == 2) tick_1Hz = 1'b1;
            end
            chk("double_tick_strobes", 32'(strobes), 32'd1);
            chk("double_tick_latency", 32'(first), 32'(SETTLE + 4));
            chk("double_tick_min", 32'(min_bcd), 32'h01);
            tick_1Hz = 1'b0;
            repeat (4) @(posedge clk_50M);
        end

        // saturation of err_count with blank frames
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, lat, strobe_after);
            if (lat < 0) chk("sat_timeout", 32'(lat), 32'(SETTLE + 4));
            if (i == 253) chk("sat_254", 32'(err_count), 32'd254);
            if (i == 254) chk("sat_255", 32'(err_count), 32'd255);
        end
        chk("sat_hold", 32'(err_count), 32'd255);
        chk("sat_valid", 32'(frame_valid), 32'h0);
        chk("sat_decode_err", 32'(decode_err), 32'h1);
        chk("sat_sec", 32'(sec_bcd), 32'hFF);

        // reset asserted during SETTLE aborts the frame
        begin
            int strobes = 0;
            @(negedge clk_50M);
            hex_m1 = 7'h40; hex_m2 = 7'h12; hex_s1 = 7'h40; hex_s2 = 7'h40;
            tick_1Hz = 1'b1;
            repeat (6) @(posedge clk_50M);
            @(negedge clk_50M);
            set_n = 1'b0;
            tick_1Hz = 1'b0;
            @(posedge clk_50M);
            #1;
            chk("midrst_min", 32'(min_bcd), 32'h0);
            chk("midrst_sec", 32'(sec_bcd), 32'h0);
            chk("midrst_errcnt", 32'(err_count), 32'h0);
            chk("midrst_flags", {28'd0, frame_valid, frame_strobe, decode_err, step_err}, 32'h0);
            @(negedge clk_50M);
            set_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk_50M);
                #1;
                if (frame_strobe) strobes++;
            end
            chk("midrst_no_strobe", 32'(strobes), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_decoder.md
# seg_display_decoder

Readback decoder and checker for the countdown timer's four seven-segment outputs. It samples the digit patterns once per 1 Hz tick and decodes them back to BCD minutes and seconds. It flags illegal patterns and illegal count steps, so board tests and simulation can confirm the display counts down correctly. It sits beside the timer top level and connects to its Hex_M1/Hex_M2/Hex_S1/Hex_S2 and CLK_ind nets.

## Interface
- SETTLE_CYCLES, 8: clk_50M cycles to wait after a tick edge before sampling the segments; legal range 1–255.
- clk_50M  input  1  system clock; all logic on its rising edge.
- set_n  input  1  reset, synchronous, active-low.
- tick_1Hz  input  1  1 Hz timer clock (CLK_ind), asynchronous level; only its rising edge is used.
- hex_m1  input  7  minutes-tens segments; active-low; bit0=a … bit6=g.
- hex_m2  input  7  minutes-units segments.
- hex_s1  input  7  seconds-tens segments.
- hex_s2  input  7  seconds-units segments.
- min_bcd  output  8  decoded minutes, {tens,units}.
- sec_bcd  output  8  decoded seconds, {tens,units}.
- frame_valid  output  1  last frame decoded legally.
- frame_strobe  output  1  one-cycle pulse when a new frame is posted.
- decode_err  output  1  sticky: an illegal pattern has been seen since reset.
- step_err  output  1  sticky: an illegal count step has been seen since reset.
- err_count  output  8  frames containing any error; saturates at 255.

## Operation
- Reset (set_n=0 at a clock edge):
  - All outputs go to 0.
  - The synchronizer flops clear.
  - The FSM returns to IDLE.
  - have_prev clears.
- tick_1Hz passes through a 2-flop synchronizer plus a third flop for edge detection: rise = sync2 & ~sync3.
- FSM states:
  - IDLE: moves to SETTLE on rise; the counter loads 0.
  - SETTLE: counts; after SETTLE_CYCLES cycles, moves to SAMPLE and registers all four hex inputs.
  - SAMPLE: decodes the registered patterns; always moves to CHECK.
  - CHECK: posts the results, pulses frame_strobe, returns to IDLE.
- A rise detected outside IDLE is dropped, not queued.
- Decode accepts only these canonical active-low patterns:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19.
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
- Any other pattern decodes to nibble 4'hF. Blank (0x7F) is illegal.
- hex_s1 decoding to 6–9 is illegal.
- Frame legal when all four digits are legal. On an illegal frame:
  - frame_valid=0.
  - decode_err is set.
  - have_prev clears.
  - BCD outputs carry the 4'hF nibbles.
- Step check, only when have_prev=1 and the current frame is legal:
  - Compute total = 60·min + sec (13-bit unsigned; max 5999) for both frames.
  - Allowed: cur == prev (hold active, or terminal 00:00), or cur == prev−1.
  - Borrow cases are covered by the total-seconds arithmetic, e.g. 10:00→09:59 and 01:00→00:59.
  - prev = 00:00 allows only 00:00.
  - Anything else sets step_err.
- After any legal frame: prev ← current, have_prev ← 1.
- err_count increments by at most 1 per frame, if that frame raised decode or step error.

## Timing
- frame_strobe rises exactly SETTLE_CYCLES+4 clock edges after the first edge at which tick_1Hz is sampled high.
- min_bcd, sec_bcd, frame_valid, the sticky flags and err_count update on the same edge that raises frame_strobe, and hold until the next frame.
- frame_strobe is high for exactly one cycle.
- Minimum spacing between accepted ticks is SETTLE_CYCLES+4 cycles.
- Sticky flags clear only on reset.
- Reset asserted mid-frame (any state) aborts the frame at that edge; no strobe is posted.

## Configuration
- SEG_STEP_CHECK_EN defined: step checking as described; prev and have_prev registers are present.
- SEG_STEP_CHECK_EN undefined:
  - The step-check logic and prev/have_prev registers are omitted.
  - step_err is tied 0.
  - err_count counts decode-error frames only.
  - Decode behaviour and timing are unchanged.

## Test plan
- Reset then a single tick with 05:00 patterns (0x40,0x12,0x40,0x40), SETTLE_CYCLES=8 → frame_strobe at edge 12 after tick sampled high; min_bcd=0x05, sec_bcd=0x00, frame_valid=1, no errors.
- Frames 10:00 then 09:59 then 09:59 then 09:58 → no step_err, err_count=0.
- Frames 00:00 then 00:00, then 00:05 (macro defined) → step_err=1 on the third frame, err_count=1; with the macro undefined, step_err stays 0 and err_count=0.
- hex_s1=0x02 (digit 6), then a blank hex_m2=0x7F frame → decode_err=1, frame_valid=0, sec tens nibble 0xF, err_count=2; the next legal frame is not step-checked.
- Second tick rise 3 cycles after the first (SETTLE_CYCLES=8) → only one frame_strobe.
- 300 erroneous frames → err_count=255 and holds.
- set_n low during SETTLE → no strobe; all outputs 0 on the following edge.
